// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent switch/button debouncers.
// Each channel has a SYNC_STAGES-deep synchroniser and a stability counter.
// A new level is accepted only after it has been held for STABLE_CYCLES
// consecutive cycles at the synchroniser output. The accepted level is
// driven on clean_out, with one-cycle rise/fall strobes that coincide with
// the change.
// Optional feature: define DEBOUNCE_TOGGLE_EN to add toggle_out, a
// push-on/push-off level that flips one cycle after each rise strobe.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 64,
    parameter int SYNC_STAGES   = 2,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic [N_CH-1:0] toggle_out
`endif
);

    // Counter only has to reach STABLE_CYCLES-1, so clog2 bits suffice.
    localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Reject configurations the counter/synchroniser structure cannot support.
    if (N_CH < 1) begin : g_bad_n_ch
        $error("debounce_multi: N_CH must be >= 1");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   clean_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   sync_lvl;

        assign sync_lvl = sync_q[SYNC_STAGES-1];

        // Synchronise the raw pin, time how long the new level persists,
        // and commit it together with its strobe when the run completes.
        // NOTE: reset is synchronous here (sampled only on the clock edge);
        // there is deliberately no asynchronous path into these flops.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
                cnt_q   <= '0;
                clean_q <= INIT_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments let every flop in this block
                // see the pre-edge values, so the shift and the compare below
                // behave like real parallel registers.
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in[i]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_lvl == clean_q) begin
                    // Back at the accepted level: any partial run is discarded.
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    clean_q <= sync_lvl;
                    cnt_q   <= '0;
                    rise_q  <= sync_lvl;
                    fall_q  <= ~sync_lvl;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign clean_out[i]  = clean_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
        logic toggle_q;

        // Push-on/push-off: flip once per accepted press, one cycle after the strobe.
        always_ff @(posedge clk) begin
            if (reset) begin
                toggle_q <= 1'b0;
            end else if (rise_q) begin
                toggle_q <= ~toggle_q;
            end
        end

        assign toggle_out[i] = toggle_q;
`endif
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed testbench for debounce_multi (N_CH=4, STABLE_CYCLES=8, SYNC_STAGES=2,
// INIT_LEVEL=0, 20 ns clock). Inputs change 1 ns after a rising edge, outputs
// are sampled 1 ns after the next rising edge. Tick number k is the k-th edge
// since the last monitor clear, so a level first applied on tick 1 is accepted
// on tick 10 (2 synchroniser edges + 8 stable cycles).
module tb_debounce_multi;

    localparam int N_CH   = 4;
    localparam int STABLE = 8;
    localparam int SYNC   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] noisy_in;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
`ifdef DEBOUNCE_TOGGLE_EN
    logic [N_CH-1:0] toggle_out;
`endif

    always #10 clk = ~clk;

    debounce_multi #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (SYNC),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy_in  (noisy_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .toggle_out(toggle_out)
`endif
    );

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] noisy;
        logic [N_CH-1:0] clean;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } vec_t;

    vec_t vecs[14];

    int n_vec = 0;
    int n_err = 0;

    // Event monitor state, refreshed on every tick.
    int              t;
    int              rise_cnt[N_CH];
    int              fall_cnt[N_CH];
    int              rise_t[N_CH];
    int              fall_t[N_CH];
    int              both_cnt;
    logic [N_CH-1:0] clean_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        t          = 0;
        both_cnt   = 0;
        clean_seen = '0;
        for (int i = 0; i < N_CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            rise_t[i]   = -1;
            fall_t[i]   = -1;
        end
    endtask

    task automatic tick(input logic r, input logic [N_CH-1:0] n);
        reset    = r;
        noisy_in = n;
        @(posedge clk);
        #1;
        t++;
        clean_seen = clean_seen | clean_out;
        if ((rise_pulse & fall_pulse) != '0) both_cnt++;
        for (int i = 0; i < N_CH; i++) begin
            if (rise_pulse[i]) begin
                rise_cnt[i]++;
                rise_t[i] = t;
            end
            if (fall_pulse[i]) begin
                fall_cnt[i]++;
                fall_t[i] = t;
            end
        end
    endtask

    task automatic reset_dut();
        tick(1'b1, '0);
        tick(1'b1, '0);
        clear_mon();
    endtask

    initial begin
        clear_mon();

        // ---- 1: reset with all inputs high, then acceptance on tick 10 ----
        for (int k = 0; k < 3; k++)  vecs[k] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
        for (int k = 3; k < 12; k++) vecs[k] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0};
        vecs[13] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
        for (int k = 0; k < 14; k++) begin
            tick(vecs[k].rst, vecs[k].noisy);
            check($sformatf("vec%0d clean_out", k),  clean_out,  vecs[k].clean);
            check($sformatf("vec%0d rise_pulse", k), rise_pulse, vecs[k].rise);
            check($sformatf("vec%0d fall_pulse", k), fall_pulse, vecs[k].fall);
        end

        // ---- 2: bounce reject on ch0 (runs of 3 and 5 < 8) ----
        reset_dut();
        check("reset clears clean_out", clean_out, 4'h0);
        for (int k = 0; k < 3; k++)  tick(1'b0, 4'b0001);
        for (int k = 0; k < 2; k++)  tick(1'b0, 4'b0000);
        for (int k = 0; k < 5; k++)  tick(1'b0, 4'b0001);
        for (int k = 0; k < 20; k++) tick(1'b0, 4'b0000);
        check("bounce clean never high", clean_seen, 4'h0);
        check("bounce rise count ch0",   rise_cnt[0], 0);
        check("bounce fall count ch0",   fall_cnt[0], 0);

        // ---- 3: press / bounce / release on ch1 ----
        reset_dut();
        for (int k = 0; k < 100; k++) tick(1'b0, 4'b0010);       // ticks 1..100
        for (int s = 0; s < 4; s++)                               // ticks 101..112
            for (int k = 0; k < 3; k++) tick(1'b0, (s % 2 == 0) ? 4'b0000 : 4'b0010);
        for (int k = 0; k < 20; k++) tick(1'b0, 4'b0000);        // final 0 from tick 113
        check("press rise count ch1", rise_cnt[1], 1);
        check("press rise tick ch1",  rise_t[1],   10);
        check("press fall count ch1", fall_cnt[1], 1);
        check("press fall tick ch1",  fall_t[1],   122);
        check("press end clean_out",  clean_out,   4'h0);
        check("press no rise+fall",   both_cnt,    0);

        // ---- 4: independent channels, ch2 at tick 1, ch3 at tick 4 ----
        reset_dut();
        for (int k = 0; k < 3; k++)  tick(1'b0, 4'b0100);
        for (int k = 0; k < 20; k++) tick(1'b0, 4'b1100);
        check("indep rise tick ch2",   rise_t[2],   10);
        check("indep rise tick ch3",   rise_t[3],   13);
        check("indep rise count ch2",  rise_cnt[2], 1);
        check("indep rise count ch3",  rise_cnt[3], 1);
        check("indep ch0/ch1 rises",   rise_cnt[0] + rise_cnt[1], 0);
        check("indep clean_out",       clean_out,   4'b1100);

        // ---- 5: reset mid-count discards the partial run on ch0 ----
        reset_dut();
        for (int k = 0; k < 6; k++) tick(1'b0, 4'b0001);
        check("midrst no early change", clean_seen, 4'h0);
        tick(1'b1, 4'b0001);
        check("midrst clean after reset", clean_out, 4'h0);
        check("midrst rise before/at reset", rise_cnt[0], 0);
        clear_mon();
        for (int k = 0; k < 20; k++) tick(1'b0, 4'b0001);
        check("midrst rise tick ch0",  rise_t[0],   10);
        check("midrst rise count ch0", rise_cnt[0], 1);
        check("midrst clean_out",      clean_out,   4'b0001);

`ifdef DEBOUNCE_TOGGLE_EN
        // ---- 6: push-on/push-off on ch1 ----
        reset_dut();
        check("toggle reset value", toggle_out, 4'h0);
        for (int k = 1; k <= 15; k++) begin                       // press 1: rise on tick 10
            tick(1'b0, 4'b0010);
            if (k == 10) check("toggle before 1st flip", toggle_out, 4'b0000);
            if (k == 11) check("toggle after 1st press", toggle_out, 4'b0010);
        end
        for (int k = 16; k <= 30; k++) tick(1'b0, 4'b0000);      // release: fall on tick 25
        check("toggle unaffected by fall", toggle_out, 4'b0010);
        for (int k = 31; k <= 45; k++) begin                      // press 2: rise on tick 40
            tick(1'b0, 4'b0010);
            if (k == 40) check("toggle before 2nd flip", toggle_out, 4'b0010);
            if (k == 41) check("toggle after 2nd press", toggle_out, 4'b0000);
        end
        check("toggle rise count ch1", rise_cnt[1], 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer, successor to the single-channel 64-count debouncer. Each channel is synchronised, then filtered by its own stability counter. The block produces a clean level per channel plus one-cycle rise and fall strobes. It sits between raw push-button or switch pins and the user logic.

Parameters:
- N_CH, 4, number of independent channels (>= 1).
- STABLE_CYCLES, 64, consecutive cycles a new level must persist before it is accepted (>= 2).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>= 2).
- INIT_LEVEL, 0, reset value of the synchroniser flops and of clean_out (1 bit, applied to all channels).
- Counter width is derived internally as $clog2(STABLE_CYCLES). It is not a user parameter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- noisy_in  input  N_CH  raw asynchronous inputs, one bit per channel.
- clean_out  output  N_CH  debounced level per channel.
- rise_pulse  output  N_CH  one-cycle strobe when clean_out goes 0->1.
- fall_pulse  output  N_CH  one-cycle strobe when clean_out goes 1->0.
- toggle_out  output  N_CH  present only with DEBOUNCE_TOGGLE_EN (see Optional Feature).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). There is no asynchronous path.
- Values while reset=1 at a clk edge:
  - synchroniser flops and clean_out = {N_CH{INIT_LEVEL}};
  - all counters = 0;
  - rise_pulse = fall_pulse = 0.
- Reset asserted mid-count discards the partial count. No pulse is generated by reset itself.
- Per channel i, the logic is fully independent of the other channels:
  - sync_i = last stage of a SYNC_STAGES flop chain fed by noisy_in[i].
  - If sync_i == clean_out[i]: cnt_i <= 0 and there is no change. Any single-cycle glitch back to the old level restarts the count.
  - If sync_i != clean_out[i] and cnt_i < STABLE_CYCLES-1: cnt_i <= cnt_i + 1.
  - If sync_i != clean_out[i] and cnt_i == STABLE_CYCLES-1: clean_out[i] <= sync_i and cnt_i <= 0. On the same edge, rise_pulse[i] <= sync_i and fall_pulse[i] <= ~sync_i.
  - Otherwise rise_pulse[i] = fall_pulse[i] = 0. Strobes are registered, high exactly one cycle, and coincident with the clean_out change.
- Latency: call the first clk edge that samples the new level edge 1. For a level held stable from then on, clean_out updates on edge SYNC_STAGES+STABLE_CYCLES. With the defaults that is edge 66.
- Rejection: a level lasting fewer than STABLE_CYCLES cycles at the synchroniser output never reaches clean_out.
- Counter saturation: cnt never exceeds STABLE_CYCLES-1. There is no wrap-around.
- Simultaneous events: several channels may transition on the same edge, and each asserts its own strobe bit. rise_pulse[i] and fall_pulse[i] are never both 1.
- Parameter check: elaboration-time $error if STABLE_CYCLES < 2, SYNC_STAGES < 2, or N_CH < 1.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined:
  - Port toggle_out[N_CH-1:0] exists.
  - Each bit flips on the edge following a cycle in which rise_pulse[i] = 1, i.e. one cycle after the strobe.
  - Reset value is 0.
  - fall_pulse has no effect on toggle_out.
  - This provides push-on/push-off switch behaviour.
- Not defined:
  - Port toggle_out and its flops are absent.
  - All other behaviour is identical.

Test Plan:
Bench settings: clk period 20 ns, N_CH=4, STABLE_CYCLES=8, SYNC_STAGES=2, INIT_LEVEL=0.
1. Reset: hold reset=1 for 3 cycles with noisy_in=4'b1111 -> clean_out=0, rise_pulse=0, fall_pulse=0. After release with inputs held, clean_out=4'b1111 on edge 10 after release, with rise_pulse=4'b1111 for that single cycle.
2. Bounce reject: ch0 pattern 1 for 3 cycles, 0 for 2, 1 for 5, then 0 -> clean_out[0] stays 0; rise_pulse[0] and fall_pulse[0] never assert.
3. Press/release: ch1 held 1 for 100 cycles, then bounce 1/0 every 3 cycles 4 times, then 0 -> rise on edge 10 after the first sampling edge; exactly one rise_pulse[1] and one fall_pulse[1]; fall occurs 10 edges after the final stable 0 is sampled.
4. Independence: ch2 rises at cycle 0 and ch3 at cycle 3, both stable -> clean_out[2] at edge 10 and clean_out[3] at edge 13; ch0/ch1 unchanged.
5. Reset mid-count: ch0 high for 6 cycles, then reset for 1 cycle, ch0 kept high -> no output change before reset; clean_out[0] rises 10 edges after the first post-reset sampling edge.
6. With DEBOUNCE_TOGGLE_EN: two clean ch1 presses -> toggle_out[1] goes 0->1 one cycle after the first rise_pulse and 1->0 one cycle after the second; without the macro, the design compiles with no toggle_out port.
